// File: rtl/rst_seq_if.sv
// Reset sequencer signal bundle: PLL lock and soft restart in,
// staged active-low resets, status and lock-loss counter out.
interface rst_seq_if;
  logic       pll_locked;
  logic       soft_rst_req;
  logic       rst_n_sdram;
  logic       rst_n_core;
  logic       rst_n_disp;
  logic       seq_done;
  logic [2:0] seq_state;
  logic [7:0] lock_lost_cnt;

  modport master (
    input  pll_locked,
    input  soft_rst_req,
    output rst_n_sdram,
    output rst_n_core,
    output rst_n_disp,
    output seq_done,
    output seq_state,
    output lock_lost_cnt
  );

  modport slave (
    output pll_locked,
    output soft_rst_req,
    input  rst_n_sdram,
    input  rst_n_core,
    input  rst_n_disp,
    input  seq_done,
    input  seq_state,
    input  lock_lost_cnt
  );
endinterface

// File: rtl/rst_seq.sv
// Staged reset sequencer: HOLD, wait for stable PLL lock, then
// release SDRAM, core and display resets in order.
// Ports: clk_sys, rst_sys (sync, active-high), bus (master side).
module rst_seq #(
  parameter int unsigned HOLD_CYC    = 64,
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned SDRAM_DLY   = 20000,
  parameter int unsigned CORE_DLY    = 16
) (
  input  logic       clk_sys,
  input  logic       rst_sys,
  rst_seq_if.master  bus
);

  if (HOLD_CYC < 1 || HOLD_CYC > 65535 ||
      LOCK_STABLE < 1 || LOCK_STABLE > 65535 ||
      SDRAM_DLY < 1 || SDRAM_DLY > 65535 ||
      CORE_DLY < 1 || CORE_DLY > 65535) begin : g_bad_param
    $error("rst_seq: parameters must be 1..65535");
  end

  localparam logic [15:0] HOLD_M1  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] LOCK_M1  = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] SDRAM_M1 = 16'(SDRAM_DLY - 1);
  localparam logic [15:0] CORE_M1  = 16'(CORE_DLY - 1);

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_LOCK  = 3'd1,
    S_SDRAM = 3'd2,
    S_CORE  = 3'd3,
    S_RUN   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  lost_q, lost_d;
  logic        sdram_q, sdram_d;
  logic        core_q, core_d;
  logic        disp_q, disp_d;
  logic        released;
  logic        lock_abort;

  // SDRAM reset already released: lock loss here is an abort
  assign released = (state_q == S_SDRAM) ||
                    (state_q == S_CORE) ||
                    (state_q == S_RUN);
  assign lock_abort = released && !bus.pll_locked;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_M1) begin
          state_d = S_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_LOCK: begin
        if (!bus.pll_locked) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_M1) begin
          state_d = S_SDRAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SDRAM: begin
        if (cnt_q == SDRAM_M1) begin
          state_d = S_CORE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_CORE: begin
        if (cnt_q == CORE_M1) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase

    if (lock_abort) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      if (lost_q != 8'hFF) begin
        lost_d = lost_q + 8'd1;
      end
    end

    if (bus.soft_rst_req) begin
      state_d = S_HOLD;
      cnt_d   = '0;
    end
  end

  // Reset outputs are registered decodes of the next state, so
  // they switch on the same edge as the state register.
  always_comb begin
    sdram_d = (state_d == S_SDRAM) ||
              (state_d == S_CORE) ||
              (state_d == S_RUN);
    core_d  = (state_d == S_CORE) ||
              (state_d == S_RUN);
    disp_d  = (state_d == S_RUN);
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      lost_q  <= '0;
      sdram_q <= 1'b0;
      core_q  <= 1'b0;
      disp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
      sdram_q <= sdram_d;
      core_q  <= core_d;
      disp_q  <= disp_d;
    end
  end

  assign bus.rst_n_sdram   = sdram_q;
  assign bus.rst_n_core    = core_q;
  assign bus.rst_n_disp    = disp_q;
  assign bus.seq_done      = disp_q;
  assign bus.seq_state     = state_q;
  assign bus.lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: directed sequence timing
// plus random stimulus against a timeline reference model.
module tb_rst_seq;

  localparam int HOLD = 4;
  localparam int LOCK = 8;
  localparam int SD   = 10;
  localparam int CR   = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   trace[$];

  // model: edges since restart, locked run, release age
  int m_age;
  int m_stable;
  int m_rel;
  int m_lost;

  rst_seq_if bus ();

  rst_seq #(
    .HOLD_CYC    (HOLD),
    .LOCK_STABLE (LOCK),
    .SDRAM_DLY   (SD),
    .CORE_DLY    (CR)
  ) dut (
    .clk_sys (clk),
    .rst_sys (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] obs_vec();
    return {bus.rst_n_sdram, bus.rst_n_core,
            bus.rst_n_disp, bus.seq_done,
            bus.seq_state, bus.lock_lost_cnt};
  endfunction

  function automatic logic [14:0] exp_vec();
    int d;
    logic [2:0] st;
    d = m_age - m_rel;
    if (m_rel < 0) st = (m_age < HOLD) ? 3'd0 : 3'd1;
    else if (d < SD) st = 3'd2;
    else if (d < SD + CR) st = 3'd3;
    else st = 3'd4;
    return {st >= 3'd2, st >= 3'd3, st == 3'd4,
            st == 3'd4, st, 8'(m_lost)};
  endfunction

  task automatic step(input bit r, input bit p, input bit s);
    rst = r;
    bus.pll_locked = p;
    bus.soft_rst_req = s;
    @(posedge clk);
    if (r) begin
      m_age = 0; m_stable = 0; m_rel = -1; m_lost = 0;
    end else if (s || (!p && m_rel >= 0)) begin
      if (!p && m_rel >= 0 && m_lost < 255) m_lost++;
      m_age = 0; m_stable = 0; m_rel = -1;
    end else if (m_age < HOLD) begin
      m_age++;
    end else if (m_rel < 0) begin
      m_age++;
      m_stable = p ? m_stable + 1 : 0;
      if (m_stable == LOCK) m_rel = m_age;
    end else begin
      m_age++;
    end
    #1;
  endtask

  // steps with lock held (dropped only at edge g), records
  // the edge index of each release and the state trace
  task automatic run_watch(input int n, input int g,
                           output int t_sd, output int t_co,
                           output int t_di);
    t_sd = -1; t_co = -1; t_di = -1;
    trace.delete();
    trace.push_back(int'(bus.seq_state));
    for (int k = 1; k <= n; k++) begin
      step(1'b0, k != g, 1'b0);
      trace.push_back(int'(bus.seq_state));
      if (t_sd < 0 && bus.rst_n_sdram === 1'b1) t_sd = k;
      if (t_co < 0 && bus.rst_n_core === 1'b1) t_co = k;
      if (t_di < 0 && bus.rst_n_disp === 1'b1) t_di = k;
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (obs_vec() !== 15'h0) begin
      errors++;
      $display("FAIL reset_vec got=%h exp=%h", obs_vec(), 15'h0);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model got=%h exp=%h",
               obs_vec(), exp_vec());
    end
  endtask

  task automatic test_nominal();
    int a, b, c;
    int seq[$];
    int exp_seq[5] = '{0, 1, 2, 3, 4};
    step(1'b1, 1'b1, 1'b0);
    run_watch(30, -1, a, b, c);
    checks++;
    if (a != 12 || b != 22 || c != 25) begin
      errors++;
      $display("FAIL nominal_times got=%0d/%0d/%0d exp=12/22/25",
               a, b, c);
    end
    foreach (trace[i])
      if (i == 0 || trace[i] != trace[i-1]) seq.push_back(trace[i]);
    checks++;
    if (seq.size() != 5) begin
      errors++;
      $display("FAIL nominal_seq_len got=%0d exp=5", seq.size());
    end else begin
      foreach (exp_seq[i]) begin
        checks++;
        if (seq[i] != exp_seq[i]) begin
          errors++;
          $display("FAIL nominal_seq[%0d] got=%0d exp=%0d",
                   i, seq[i], exp_seq[i]);
        end
      end
    end
    checks++;
    if (bus.seq_done !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL nominal_run got=%h exp=%h",
               obs_vec(), exp_vec());
    end
  endtask

  task automatic test_lock_glitch();
    int a, b, c;
    step(1'b1, 1'b1, 1'b0);
    run_watch(40, 10, a, b, c);
    checks++;
    if (a != 18 || b != 28 || c != 31) begin
      errors++;
      $display("FAIL glitch_times got=%0d/%0d/%0d exp=18/28/31",
               a, b, c);
    end
    checks++;
    if (trace[10] != 1 || trace[11] != 1) begin
      errors++;
      $display("FAIL glitch_state got=%0d,%0d exp=1,1",
               trace[10], trace[11]);
    end
    checks++;
    if (bus.lock_lost_cnt !== 8'd0) begin
      errors++;
      $display("FAIL glitch_lost got=%0d exp=0", bus.lock_lost_cnt);
    end
  endtask

  task automatic test_run_loss();
    int a, b, c;
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== 15'h001) begin
      errors++;
      $display("FAIL runloss_vec got=%h exp=%h", obs_vec(), 15'h001);
    end
    run_watch(30, -1, a, b, c);
    checks++;
    if (a != 12 || b != 22 || c != 25) begin
      errors++;
      $display("FAIL runloss_times got=%0d/%0d/%0d exp=12/22/25",
               a, b, c);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL runloss_model got=%h exp=%h",
               obs_vec(), exp_vec());
    end
  endtask

  task automatic test_soft();
    int a, b, c;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.seq_state !== 3'd0) begin
      errors++;
      $display("FAIL soft_hold got=%0d exp=0", bus.seq_state);
    end
    run_watch(22, -1, a, b, c);
    checks++;
    if (trace[3] != 0 || trace[4] != 1) begin
      errors++;
      $display("FAIL soft_hold_len got=%0d,%0d exp=0,1",
               trace[3], trace[4]);
    end
    checks++;
    if (a != 12 || b != 22 || bus.seq_state !== 3'd3) begin
      errors++;
      $display("FAIL soft_times got=%0d/%0d st=%0d exp=12/22 st=3",
               a, b, bus.seq_state);
    end
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (obs_vec() !== 15'h0) begin
      errors++;
      $display("FAIL soft_core got=%h exp=%h", obs_vec(), 15'h0);
    end
  endtask

  task automatic test_simultaneous();
    int a, b, c;
    step(1'b1, 1'b1, 1'b0);
    run_watch(26, -1, a, b, c);
    step(1'b0, 1'b0, 1'b0);
    run_watch(26, -1, a, b, c);
    checks++;
    if (bus.seq_state !== 3'd4) begin
      errors++;
      $display("FAIL simul_run got=%0d exp=4", bus.seq_state);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_vec() !== 15'h002) begin
      errors++;
      $display("FAIL simul_vec got=%h exp=%h", obs_vec(), 15'h002);
    end
  endtask

  task automatic test_saturation();
    int k;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      k = 0;
      while (m_rel < 0 && k < 20) begin
        step(1'b0, 1'b1, 1'b0);
        k++;
      end
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL sat_abort[%0d] got=%h exp=%h",
                 i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.lock_lost_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_cnt got=%0d exp=255", bus.lock_lost_cnt);
    end
    run_watch(30, -1, k, k, k);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (obs_vec() !== 15'h0) begin
      errors++;
      $display("FAIL sat_rst got=%h exp=%h", obs_vec(), 15'h0);
    end
  endtask

  task automatic test_random();
    bit r, p, s;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom % 700) == 0;
      p = ($urandom % 60) != 0;
      s = ($urandom % 300) == 0;
      step(r, p, s);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d] got=%h exp=%h",
                 i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    bus.soft_rst_req = 1'b0;
    m_age = 0; m_stable = 0; m_rel = -1; m_lost = 0;
    test_reset();
    test_nominal();
    test_lock_glitch();
    test_run_loss();
    test_soft();
    test_simultaneous();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 64: cycles all resets stay asserted in HOLD.
REQ-002 SHALL have parameter LOCK_STABLE, default 1024: consecutive cycles pll_locked must stay high before release starts.
REQ-003 SHALL have parameter SDRAM_DLY, default 20000: cycles between SDRAM reset release and core reset release (200 us at 100 MHz).
REQ-004 SHALL have parameter CORE_DLY, default 16: cycles between core reset release and display reset release.
REQ-005 SHALL accept every parameter only in the range 1..65535; the counter SHALL be 16 bits.
REQ-006 SHALL have port clk_sys, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_sys, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port pll_locked, input, 1: PLL lock, already synchronous to clk_sys.
REQ-009 SHALL have port soft_rst_req, input, 1: software restart request, level-sampled each cycle.
REQ-010 SHALL have port rst_n_sdram, output, 1: SDRAM controller reset, active-low, registered.
REQ-011 SHALL have port rst_n_core, output, 1: core datapath reset, active-low, registered.
REQ-012 SHALL have port rst_n_disp, output, 1: display interface reset, active-low, registered.
REQ-013 SHALL have port seq_done, output, 1: high only in RUN.
REQ-014 SHALL have port seq_state, output, 3: current state code.
REQ-015 SHALL have port lock_lost_cnt, output, 8: saturating count of lock-loss events.

Function
REQ-016 SHALL implement the states HOLD=0, LOCK=1, SDRAM=2, CORE=3, RUN=4; codes 5-7 SHALL go to HOLD on the next edge.
REQ-017 SHALL derive all outputs from registered state: rst_n_sdram=1 in SDRAM/CORE/RUN; rst_n_core=1 in CORE/RUN; rst_n_disp=1 and seq_done=1 in RUN only.
REQ-018 SHALL, in HOLD: increment cnt each cycle; at cnt==HOLD_CYC-1 go to LOCK with cnt=0 (HOLD lasts exactly HOLD_CYC cycles).
REQ-019 SHALL, in LOCK: clear cnt while pll_locked=0, else increment; at cnt==LOCK_STABLE-1 with pll_locked=1 go to SDRAM with cnt=0.
REQ-020 SHALL, in SDRAM: at cnt==SDRAM_DLY-1 go to CORE with cnt=0.
REQ-021 SHALL, in CORE: at cnt==CORE_DLY-1 go to RUN with cnt=0.
REQ-022 SHALL hold RUN, with cnt at 0, until an abort.
REQ-023 SHALL abort on pll_locked=0 in SDRAM/CORE/RUN: next state HOLD, cnt=0, all resets low from the next edge.
REQ-024 SHALL abort on soft_rst_req=1 in any state: next state HOLD, cnt=0; in HOLD this restarts the hold count.
REQ-025 SHALL give soft_rst_req and lock loss the same result when both occur in one cycle; lock_lost_cnt SHALL still increment.
REQ-026 SHALL increment lock_lost_cnt on each lock-loss abort from SDRAM/CORE/RUN, saturating at 255; lock loss in HOLD or LOCK SHALL NOT count.
REQ-027 SHALL ensure no output is ever released out of order: rst_n_core never rises before rst_n_sdram, and rst_n_disp never rises before rst_n_core.

Reset
REQ-028 SHALL, while rst_sys=1 at a rising edge, force: state=HOLD, cnt=0, rst_n_sdram=rst_n_core=rst_n_disp=0, seq_done=0, seq_state=0, lock_lost_cnt=0.
REQ-029 SHALL apply rst_sys mid-sequence or in RUN on the same edge, overriding every other condition.
REQ-030 SHALL restart from HOLD cycle 0 on the first edge after rst_sys deasserts.

Verification (HOLD_CYC=4, LOCK_STABLE=8, SDRAM_DLY=10, CORE_DLY=3)
REQ-031 SHALL cover the nominal run: rst_sys released, pll_locked held 1 -> rst_n_sdram rises 12 cycles after the first non-reset edge, rst_n_core at 22, rst_n_disp and seq_done at 25, seq_state sequence 0,1,2,3,4.
REQ-032 SHALL cover a lock glitch in LOCK: pll_locked low 1 cycle at LOCK cnt=5 -> stay in LOCK, lock-stable count restarts, rst_n_sdram delayed by 6 cycles, lock_lost_cnt=0.
REQ-033 SHALL cover lock loss in RUN: pll_locked falls -> next edge all resets 0, seq_state=0, lock_lost_cnt=1; lock restored -> full sequence repeats with the same timing.
REQ-034 SHALL cover soft_rst_req pulsed at HOLD cnt=2 and again in CORE -> first pulse extends HOLD to 7 total cycles; second pulse drops all outputs next edge, lock_lost_cnt unchanged.
REQ-035 SHALL cover lock_lost_cnt saturation: 300 lock-loss aborts from SDRAM -> lock_lost_cnt=255; then rst_sys=1 -> all outputs 0 on that edge.
REQ-036 SHALL cover a simultaneous abort: soft_rst_req=1 and pll_locked=0 in the same cycle in RUN -> HOLD, lock_lost_cnt increments by exactly 1.
